datapath_delay_ctrl: RTL and testbench

Run-time controller for a programmable-depth datapath delay line. It owns a tapped register chain of MAX_DELAY stages and selects the output tap from a configured delay. It accepts delay-change requests over a valid/ready config port and sequences each change so the output stream never mixes items from the old and new delay settings. It sits between a streaming producer and consumer wherever a fixed shift-register delay has to become software-tunable.

---
 rtl/datapath_delay_pkg.sv | 20 ++
 rtl/datapath_delay_ctrl_chain.sv | 44 ++++
 rtl/datapath_delay_ctrl.sv | 144 ++++++++++++++
 tb/tb_datapath_delay_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_delay_pkg.sv
// rtl/datapath_delay_pkg.sv - shared types and widths for the datapath delay controller
// Purpose: controller FSM states, chain stage type and delay-field width.
// Ports: none (package).
package datapath_delay_pkg;

  localparam int PKG_WIDTH     = 32;
  localparam int PKG_MAX_DELAY = 16;
  localparam int DW            = $clog2(PKG_MAX_DELAY + 1);

  typedef enum logic [0:0] {
    ACTIVE = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [PKG_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/datapath_delay_ctrl_chain.sv
// rtl/datapath_delay_ctrl_chain.sv - tapped shift-register chain with valid flush
// Purpose: MAX_DELAY stages of stage_t shifting every cycle; every tap exposed.
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   flush           clears every valid bit (including the incoming one) at this edge
//   in_stage        value loaded into stage 1
//   taps[i]         contents of stage i+1
module delay_tap_chain
  import datapath_delay_pkg::*;
#(
  parameter int MAX_DELAY = PKG_MAX_DELAY
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  stage_t in_stage,
  output stage_t taps [MAX_DELAY]
);

  stage_t stages [MAX_DELAY];

  // Data keeps shifting through a flush; only the valid bits are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0].data  <= in_stage.data;
      stages[0].valid <= in_stage.valid && !flush;
      for (int i = 1; i < MAX_DELAY; i++) begin
        stages[i].data  <= stages[i-1].data;
        stages[i].valid <= stages[i-1].valid && !flush;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_DELAY; i++) begin
      taps[i] = stages[i];
    end
  end

endmodule

// File: rtl/datapath_delay_ctrl.sv
// rtl/datapath_delay_ctrl.sv - run-time programmable-depth datapath delay controller
// Purpose: selects the output tap of a delay chain and sequences delay changes.
// Build option: DATAPATH_DELAY_CTRL_DRAIN_EN compiles in the DRAIN state; without it
//   a legal change applies at once and discards in-flight items.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   in_valid/in_data/in_ready      input stream
//   out_valid/out_data             delayed output stream (no backpressure)
//   cfg_valid/cfg_delay/cfg_ready  delay-change request
//   cfg_err                        one-cycle pulse after a rejected request
//   cur_delay                      delay currently applied
//   busy                           delay change in progress
module datapath_delay_ctrl
  import datapath_delay_pkg::*;
#(
  parameter int WIDTH         = PKG_WIDTH,
  parameter int MAX_DELAY     = PKG_MAX_DELAY,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_valid,
  input  logic [DW-1:0]    cfg_delay,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DW-1:0]    cur_delay,
  output logic             busy
);

  logic   accept;
  logic   flush;
  logic   cfg_legal;
  stage_t in_stage;
  stage_t tap;
  stage_t taps [MAX_DELAY];

  assign accept    = in_valid && in_ready;
  assign cfg_legal = (cfg_delay <= DW'(MAX_DELAY));
  assign in_stage  = '{valid: accept, data: in_data};

  delay_tap_chain #(.MAX_DELAY(MAX_DELAY)) u_chain (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_stage (in_stage),
    .taps     (taps)
  );

  // Delay 0 bypasses the chain combinationally; otherwise read stage[cur_delay].
  always_comb begin
    tap = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (cur_delay == DW'(i + 1)) tap = taps[i];
    end
    if (cur_delay == '0) begin
      out_valid = accept;
      out_data  = in_data;
    end else begin
      out_valid = tap.valid;
      out_data  = tap.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cfg_err <= 1'b0;
    else        cfg_err <= cfg_valid && cfg_ready && !cfg_legal;
  end

`ifdef DATAPATH_DELAY_CTRL_DRAIN_EN
  state_t        state, state_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic [DW-1:0] pending_delay, pending_n;
  logic [DW-1:0] cur_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ACTIVE;
      drain_cnt     <= '0;
      pending_delay <= DW'(DEFAULT_DELAY);
      cur_delay     <= DW'(DEFAULT_DELAY);
    end else begin
      state         <= state_n;
      drain_cnt     <= drain_cnt_n;
      pending_delay <= pending_n;
      cur_delay     <= cur_n;
    end
  end

  // Stale items left in stages deeper than the old delay would otherwise
  // resurface under a larger new delay, so every actual switch flushes the chain.
  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    pending_n   = pending_delay;
    cur_n       = cur_delay;
    flush       = 1'b0;
    in_ready    = 1'b1;
    cfg_ready   = 1'b1;
    busy        = 1'b0;
    case (state)
      ACTIVE: begin
        if (cfg_valid && cfg_legal) begin
          pending_n = cfg_delay;
          if (cur_delay == '0 || cfg_delay == cur_delay) begin
            cur_n = cfg_delay;
            flush = (cfg_delay != cur_delay);
          end else begin
            drain_cnt_n = cur_delay;
            state_n     = DRAIN;
          end
        end
      end
      DRAIN: begin
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;
        busy        = 1'b1;
        drain_cnt_n = drain_cnt - DW'(1);
        if (drain_cnt == DW'(1)) begin
          cur_n   = pending_delay;
          state_n = ACTIVE;
          flush   = 1'b1;
        end
      end
      default: state_n = ACTIVE;
    endcase
  end
`else
  always_ff @(posedge clk) begin
    if (!reset)                      cur_delay <= DW'(DEFAULT_DELAY);
    else if (cfg_valid && cfg_legal) cur_delay <= cfg_delay;
  end

  assign in_ready  = 1'b1;
  assign cfg_ready = 1'b1;
  assign busy      = 1'b0;
  assign flush     = cfg_valid && cfg_legal;
`endif

endmodule

// File: tb/tb_datapath_delay_ctrl.sv
// tb/tb_datapath_delay_ctrl.sv - directed self-checking bench for datapath_delay_ctrl
module tb_datapath_delay_ctrl;
  import datapath_delay_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          cfg_valid;
  logic [DW-1:0] cfg_delay;
  logic          cfg_ready;
  logic          cfg_err;
  logic [DW-1:0] cur_delay;
  logic          busy;

  int          checks = 0;
  int          errors = 0;
  logic        exp_v;
  logic [31:0] exp_d;
  logic        exp_busy;
  int          idx;

  always #5 clk = ~clk;

  datapath_delay_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cfg_valid (cfg_valid),
    .cfg_delay (cfg_delay),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_delay (cur_delay),
    .busy      (busy)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    repeat (n) next_cycle;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_valid = 1'b0; cfg_delay = '0;
    repeat (3) next_cycle;
    reset = 1'b1;
    settle;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %0b want 1", cfg_ready); end
    checks++; if (cur_delay !== DW'(4)) begin errors++; $display("FAIL reset_cur_delay got %0d want 4", cur_delay); end
    next_cycle;
  endtask

  task automatic test_stream;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_data = 32'h10 + c;
      settle;
      exp_v = (c >= 4);
      exp_d = 32'h10 + c - 4;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL stream_data c=%0d got %h want %h", c, out_data, exp_d); end
      end
      next_cycle;
    end
    idle(4);
  endtask

  task automatic test_cfg_err;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_data = 32'h20 + c;
      cfg_valid = (c == 2); cfg_delay = DW'(17);
      settle;
      exp_v = (c >= 4);
      exp_d = 32'h20 + c - 4;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL err_stream_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL err_stream_data c=%0d got %h want %h", c, out_data, exp_d); end
      end
      checks++; if (cfg_err !== (c == 3)) begin errors++; $display("FAIL cfg_err c=%0d got %0b want %0b", c, cfg_err, (c == 3)); end
      if (c == 4) begin
        checks++; if (cur_delay !== DW'(4)) begin errors++; $display("FAIL err_cur_delay got %0d want 4", cur_delay); end
      end
      next_cycle;
    end
    cfg_valid = 1'b0;
    idle(4);
  endtask

`ifdef DATAPATH_DELAY_CTRL_DRAIN_EN
  task automatic test_change;
    idx = 0;
    for (int c = 0; c < 22; c++) begin
      in_valid = (idx < 6); in_data = 32'h50 + idx;
      cfg_valid = (c == 2); cfg_delay = DW'(9);
      settle;
      exp_busy = (c >= 3 && c <= 6);
      case (c)
        4:  begin exp_v = 1'b1; exp_d = 32'h50; end
        5:  begin exp_v = 1'b1; exp_d = 32'h51; end
        6:  begin exp_v = 1'b1; exp_d = 32'h52; end
        16: begin exp_v = 1'b1; exp_d = 32'h53; end
        17: begin exp_v = 1'b1; exp_d = 32'h54; end
        18: begin exp_v = 1'b1; exp_d = 32'h55; end
        default: begin exp_v = 1'b0; exp_d = '0; end
      endcase
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL drain_busy c=%0d got %0b want %0b", c, busy, exp_busy); end
      checks++; if (in_ready !== !exp_busy) begin errors++; $display("FAIL drain_in_ready c=%0d got %0b want %0b", c, in_ready, !exp_busy); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL drain_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL drain_data c=%0d got %h want %h", c, out_data, exp_d); end
      end
      if (c == 6) begin
        checks++; if (cur_delay !== DW'(4)) begin errors++; $display("FAIL drain_old_delay got %0d want 4", cur_delay); end
      end
      if (c == 7) begin
        checks++; if (cur_delay !== DW'(9)) begin errors++; $display("FAIL drain_new_delay got %0d want 9", cur_delay); end
      end
      if (in_valid && !exp_busy) idx++;
      next_cycle;
    end
    idle(4);
  endtask
`else
  task automatic test_change;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 6); in_data = 32'h30 + c;
      cfg_valid = (c == 3); cfg_delay = DW'(2);
      settle;
      exp_v = (c == 6 || c == 7);
      exp_d = 32'h30 + c - 2;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL flush_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL flush_data c=%0d got %h want %h", c, out_data, exp_d); end
      end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_hs c=%0d busy=%0b in_ready=%0b want 0/1", c, busy, in_ready); end
      if (c == 4) begin
        checks++; if (cur_delay !== DW'(2)) begin errors++; $display("FAIL flush_cur_delay got %0d want 2", cur_delay); end
      end
      next_cycle;
    end
    idle(4);
  endtask
`endif

  task automatic test_delay0;
    int n;
    in_valid = 1'b0; cfg_valid = 1'b1; cfg_delay = '0;
    next_cycle;
    cfg_valid = 1'b0;
    settle;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      next_cycle;
      settle;
      n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL delay0_timeout busy=%0b want 0", busy); end
    checks++; if (cur_delay !== '0) begin errors++; $display("FAIL delay0_cur got %0d want 0", cur_delay); end
    next_cycle;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 6); in_data = 32'h40 + c;
      cfg_valid = (c == 2); cfg_delay = DW'(3);
      settle;
      if (c <= 2) begin
        exp_v = 1'b1; exp_d = 32'h40 + c;
      end else begin
        exp_v = (c >= 6 && c <= 8); exp_d = 32'h40 + c - 3;
      end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL bypass_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL bypass_data c=%0d got %h want %h", c, out_data, exp_d); end
      end
      if (c == 3) begin
        checks++; if (cur_delay !== DW'(3)) begin errors++; $display("FAIL switch3_cur got %0d want 3", cur_delay); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL switch3_busy got %0b want 0", busy); end
      end
      next_cycle;
    end
    idle(6);
  endtask

  task automatic test_reset_mid_change;
    in_valid = 1'b1; in_data = 32'h60; cfg_valid = 1'b1; cfg_delay = DW'(7);
    next_cycle;
    in_valid = 1'b0; cfg_valid = 1'b0;
    settle;
`ifdef DATAPATH_DELAY_CTRL_DRAIN_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy got %0b want 1", busy); end
`else
    checks++; if (cur_delay !== DW'(7)) begin errors++; $display("FAIL midreset_cur7 got %0d want 7", cur_delay); end
`endif
    next_cycle;
    reset = 1'b0;
    next_cycle;
    reset = 1'b1;
    settle;
    checks++; if (cur_delay !== DW'(4)) begin errors++; $display("FAIL midreset_cur got %0d want 4", cur_delay); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_state busy=%0b in_ready=%0b want 0/1", busy, in_ready); end
    repeat (12) next_cycle;
    settle;
    checks++; if (cur_delay !== DW'(4)) begin errors++; $display("FAIL midreset_pending got %0d want 4", cur_delay); end
    next_cycle;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_cfg_err;
    test_change;
    test_delay0;
    test_reset_mid_change;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
